// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundle between the datapath side and the seven-segment scan controller.
//
// Signals:
//   wr_en       write strobe into the shadow digit file
//   wr_addr     digit index, 0 = leftmost digit (seg_com bit 7)
//   wr_data     digit value 0..15
//   wr_dp       decimal point of the addressed digit
//   wr_on       enable of the addressed digit
//   commit      request to promote shadow to active at the next frame boundary
//   commit_done one-cycle pulse after the promotion
//   frame_tick  one-cycle pulse after every frame boundary
//   seg_com     digit select, active-low
//   seg_data    segments {dp,g,f,e,d,c,b,a}, active-high
//
// Modports:
//   master  the writer / board side (drives the write port and commit)
//   slave   the scan controller
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_on;
  logic       commit;
  logic       commit_done;
  logic       frame_tick;
  logic [7:0] seg_com;
  logic [7:0] seg_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, wr_on, commit,
    input  commit_done, frame_tick, seg_com, seg_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, wr_on, commit,
    output commit_done, frame_tick, seg_com, seg_data
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an up-to-8-digit common-anode
// seven-segment display. Each digit owns a fixed slot of SCAN_DIV cycles;
// the first BLANK_CYC cycles of each slot are dark to suppress ghosting.
// Digit contents are written into a shadow file and promoted to the
// displayed (active) file atomically at a frame boundary after a commit.
//
// Parameters:
//   NUM_DIGITS  scanned digits, 1..8
//   SCAN_DIV    mclk cycles per digit slot, >= BLANK_CYC+2
//   BLANK_CYC   dark cycles at the start of each slot
//
// Ports:
//   mclk        system clock, rising edge
//   rst         asynchronous active-low reset
//   bus         seg_scan_ctrl_if.slave (write port, commit handshake,
//               frame_tick, seg_com/seg_data display pins)
//
// Build option:
//   SEG_HEX_DECODE_EN  when defined, values 10..15 show A,b,C,d,E,F;
//                      otherwise those values light no segments (dp still
//                      follows the entry).
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 10000,
  parameter int BLANK_CYC  = 4
) (
  input  logic           mclk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]       NUM_D4    = 4'(NUM_DIGITS);
  // Entry layout: [5:2] value, [1] dp, [0] on. Reset shows a lit "0".
  localparam logic [5:0]       ENTRY_RST = 6'b000001;

  // Seven-segment decode, bit order gfedcba.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] segs;
    case (value)
      4'd0:    segs = 7'h3F;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5B;
      4'd3:    segs = 7'h4F;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6D;
      4'd6:    segs = 7'h7D;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7F;
      4'd9:    segs = 7'h67;
`ifdef SEG_HEX_DECODE_EN
      4'd10:   segs = 7'h77;
      4'd11:   segs = 7'h7C;
      4'd12:   segs = 7'h39;
      4'd13:   segs = 7'h5E;
      4'd14:   segs = 7'h79;
      4'd15:   segs = 7'h71;
`endif
      default: segs = 7'h00;
    endcase
    return segs;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_pending;
  logic [5:0]       r_shadow [0:7];
  logic [5:0]       r_active [0:7];
  logic [7:0]       r_seg_com;
  logic [7:0]       r_seg_data;
  logic             r_commit_done;
  logic             r_frame_tick;

  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_copy;
  logic             w_wr_ok;
  logic             w_blank;
  logic [5:0]       w_cur;
  logic [7:0]       w_com_nxt;
  logic [7:0]       w_data_nxt;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  // A commit arriving on the boundary edge itself is honoured immediately.
  assign w_copy      = w_frame_end && (r_pending || bus.commit);
  assign w_wr_ok     = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_D4);
  assign w_blank     = (r_cnt < CNT_BLANK);
  assign w_cur       = r_active[r_idx];

  // Next display values from the current slot position and active entry.
  always_comb begin
    w_com_nxt  = 8'hFF;
    w_data_nxt = 8'h00;
    if (!w_blank && w_cur[0]) begin
      // Digit 0 is the leftmost, driven on seg_com bit 7.
      w_com_nxt  = ~(8'h80 >> r_idx);
      w_data_nxt = {w_cur[1], seg_decode(w_cur[5:2])};
    end else begin
      w_com_nxt  = 8'hFF;
      w_data_nxt = 8'h00;
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_cnt <= CNT_ZERO;
      r_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_cnt <= CNT_ZERO;
      if (r_idx == IDX_LAST) begin
        r_idx <= 3'd0;
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Shadow writes and the frame-boundary shadow-to-active copy.
  // Non-blocking semantics make the copy see pre-edge shadow contents,
  // so a write on the copy edge stays in shadow only.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= ENTRY_RST;
        r_active[i] <= ENTRY_RST;
      end
    end else begin
      if (w_wr_ok) begin
        r_shadow[bus.wr_addr] <= {bus.wr_data, bus.wr_dp, bus.wr_on};
      end
      if (w_copy) begin
        for (int i = 0; i < 8; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  // Commit request latch; multiple requests before a boundary collapse.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (w_copy) begin
      r_pending <= 1'b0;
    end else if (bus.commit) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Registered display pins and status pulses.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_seg_com     <= 8'hFF;
      r_seg_data    <= 8'h00;
      r_frame_tick  <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_seg_com     <= w_com_nxt;
      r_seg_data    <= w_data_nxt;
      r_frame_tick  <= w_frame_end;
      r_commit_done <= w_copy;
    end
  end

  assign bus.seg_com     = r_seg_com;
  assign bus.seg_data    = r_seg_data;
  assign bus.frame_tick  = r_frame_tick;
  assign bus.commit_done = r_commit_done;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It owns the shared `seg_com`/`seg_data` pins and gives each digit a fixed time slot, which removes multiple drivers on those pins. Digit values are written into a shadow register file through a simple write port and promoted to the displayed set atomically at a frame boundary. The block sits between the counter/datapath blocks and the board display pins.

## Interface
- `NUM_DIGITS`, default 8: number of scanned digits, legal range 1..8.
- `SCAN_DIV`, default 10000: `mclk` cycles per digit slot, must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 4: cycles at the start of each slot with all digits off, for ghost suppression.
- `mclk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe into the shadow file.
- `wr_addr`  in  3  digit index; 0 is the leftmost digit (`seg_com` bit 7).
- `wr_data`  in  4  digit value, 0..15.
- `wr_dp`  in  1  decimal point for the addressed digit.
- `wr_on`  in  1  digit enable for the addressed digit.
- `commit`  in  1  request to copy shadow to active at the next frame boundary.
- `commit_done`  out  1  one-cycle pulse after the copy.
- `frame_tick`  out  1  one-cycle pulse at every frame boundary.
- `seg_com`  out  8  digit select, active-low, registered.
- `seg_data`  out  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered.

## Operation
- **Slot counter `cnt`:** counts 0..`SCAN_DIV`-1, then wraps to 0.
- **Digit index `idx`:** 0..`NUM_DIGITS`-1. Increments when `cnt`==`SCAN_DIV`-1 and wraps to 0 after `NUM_DIGITS`-1.
- **Frame boundary:** `idx`==`NUM_DIGITS`-1 and `cnt`==`SCAN_DIV`-1. `frame_tick`=1 in the following cycle.
- **Shadow file:** per digit, {value[3:0], dp, on}.
  - When `wr_en`=1 and `wr_addr`<`NUM_DIGITS`, the addressed entry is written on that edge.
  - When `wr_addr`≥`NUM_DIGITS`, the write is ignored.
- **Active file:** same layout as the shadow file and drives the display. It is written only by the commit copy.
- **Commit handshake:**
  - `commit`=1 sets `pending`.
  - At a frame-boundary edge, if `pending` or `commit` is 1: all shadow entries are copied to active, `pending` clears, and `commit_done`=1 in the next cycle.
  - Repeated `commit` pulses before the boundary collapse into a single copy.
- **Write during copy edge:** the copy uses the pre-edge shadow contents. The new write lands in shadow only and waits for the next commit.
- **Output per slot:**
  - While `cnt`<`BLANK_CYC`: `seg_com`=8'hFF and `seg_data`=8'h00.
  - Otherwise, if active[`idx`].on=1: `seg_com` has only bit (7-`idx`) at 0, and `seg_data`={dp, decode(value)}.
  - Otherwise: `seg_com`=8'hFF and `seg_data`=8'h00; the slot time is still consumed.
- **Decode table, gfedcba:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=67
  - 10..15: see Configuration.
- **Unused digits:** `seg_com` bits for digits ≥`NUM_DIGITS` are held at 1.

## Timing
- **Reset state:** `cnt`=0, `idx`=0, `pending`=0, `seg_com`=8'hFF, `seg_data`=8'h00, `commit_done`=0, `frame_tick`=0.
- **Reset contents:** all shadow and active entries are value=0, dp=0, on=1, so the display shows "00000000" after blanking.
- **Output latency:** `seg_com`/`seg_data` reflect (`cnt`,`idx`, active) of the previous cycle, one register stage. The first lit cycle of a slot is the cycle after `cnt`==`BLANK_CYC`.
- **Write-to-display latency:** shadow write, then `commit`, then the copy at the next frame boundary. Displayed from the first non-blank cycle of slot 0 of the next frame.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). Pending commits and uncommitted shadow writes are lost.
- **Release:** reset is released synchronously to `mclk` by the upstream reset synchronizer; the first count occurs on the first edge after release.

## Configuration
- **`SEG_HEX_DECODE_EN` defined:** values 10..15 decode to A=77, b=7C, C=39, d=5E, E=79, F=71.
- **Not defined:** values 10..15 decode to 00 (segments blank), while dp is still driven from the entry.
- No other behaviour changes with the macro.

## Test plan
- **Reset:** assert `rst`=0 mid-slot → `seg_com`=FF and `seg_data`=00 immediately. After release with `SCAN_DIV`=16 and `BLANK_CYC`=2, cycle 3 shows `seg_com`=7F, `seg_data`=3F.
- **Scan order:** default contents, `NUM_DIGITS`=8 → `seg_com` steps 7F, BF, DF, EF, F7, FB, FD, FE, 16 cycles each with 2 blank cycles. `frame_tick` pulses every 128 cycles.
- **Commit:** write addr 1 = value 5 with dp, `commit` at mid-frame → display unchanged until the boundary. `commit_done` pulses once. The next frame's slot 1 shows `seg_data`=ED.
- **Write/commit at boundary:** `commit` and a write to addr 0 = 9 on the boundary edge → the copy takes the old value 0. The write is shown only after a second commit.
- **Disabled digit and bad address:** `on`=0 at addr 3 and committed → slot 3 shows FF/00 with unchanged slot length. A write with `wr_addr`=7 when `NUM_DIGITS`=6 changes nothing, and `seg_com`[1:0] stay 1.
- **Hex decode:** value 12 committed → `seg_data`=39 with `SEG_HEX_DECODE_EN`, 00 without it.
